// File: rtl/axi4stream_rr_arbiter_pkg.sv
// Shared types and helpers for the AXI4-Stream round-robin arbiter.
// Optional feature macro used by the design: AXI4STREAM_RR_ARBITER_TID_EN.
package axi4stream_rr_arbiter_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int SKID_DEPTH = 2;
  localparam int MAX_PORTS  = 16;

  // One-hot winner: first requester strictly after 'last', wrapping at num_ports.
  function automatic logic [MAX_PORTS-1:0] next_rr(
    input logic [MAX_PORTS-1:0] req,
    input logic [MAX_PORTS-1:0] last,
    input logic [4:0]           num_ports
  );
    logic [4:0] last_idx;
    logic [4:0] idx;
    logic       found;
    next_rr  = '0;
    last_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (last[i]) last_idx = 5'(i);
    end
    for (int k = 1; k <= MAX_PORTS; k++) begin
      idx = 5'(int'(last_idx) + k);
      if (idx >= num_ports) idx = idx - num_ports;
      if ((5'(k) <= num_ports) && !found && req[idx[3:0]]) begin
        next_rr[idx[3:0]] = 1'b1;
        found             = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/axi4stream_rr_arbiter_skid.sv
// Two-entry registered output buffer; in_ready comes straight from a flop.
// Payload width includes the source index when AXI4STREAM_RR_ARBITER_TID_EN is set.
module axi4stream_skid_buffer
  import axi4stream_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [1:0]       occ_q, occ_d;
  logic             rdy_q;
  logic             push, pop;

  assign push      = in_valid & rdy_q;
  assign pop       = (occ_q != 2'd0) & out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = mem_q[0];

  // Pop shifts first, so the post-pop occupancy is the free slot for a push.
  always_comb begin
    mem_d = mem_q;
    occ_d = occ_q;
    if (pop) begin
      mem_d[0] = mem_q[1];
      occ_d    = occ_d - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) mem_d[0] = in_data;
      else               mem_d[1] = in_data;
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      occ_q <= 2'd0;
      rdy_q <= 1'b1;
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      rdy_q <= (occ_d < 2'(SKID_DEPTH));
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/axi4stream_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Stream output among NUM_PORTS producers.
// Define AXI4STREAM_RR_ARBITER_TID_EN to add m_axis_tid (source port of each beat).
module axi4stream_rr_arbiter
  import axi4stream_rr_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            busy
`ifdef AXI4STREAM_RR_ARBITER_TID_EN
  ,
  output logic [$clog2(NUM_PORTS)-1:0]    m_axis_tid
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int TID_W = $clog2(NUM_PORTS);
`ifdef AXI4STREAM_RR_ARBITER_TID_EN
  localparam int PAY_W = DATA_WIDTH + TID_W;
`else
  localparam int PAY_W = DATA_WIDTH;
`endif

  arb_state_t           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [NUM_PORTS-1:0] last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MAX_PORTS-1:0] rr_win;
  logic                 granted_valid;
  logic                 accept;
  logic                 skid_in_ready;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [PAY_W-1:0]     skid_in, skid_out;

  assign granted_valid = |(s_axis_tvalid & grant_q);
  assign accept        = granted_valid & skid_in_ready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= {1'b1, {(NUM_PORTS-1){1'b0}}};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rr_win  = next_rr(MAX_PORTS'(s_axis_tvalid), MAX_PORTS'(last_q), 5'(NUM_PORTS));
    case (state_q)
      IDLE: begin
        if (|s_axis_tvalid) begin
          state_d = GRANT;
          grant_d = NUM_PORTS'(rr_win);
          last_d  = NUM_PORTS'(rr_win);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // A dropped valid and a burst-final beat release identically.
        if (!granted_valid || (accept && (cnt_q == CNT_W'(MAX_BURST - 1)))) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant         = grant_q;
    busy          = (state_q == GRANT);
    s_axis_tready = grant_q & {NUM_PORTS{skid_in_ready}};
    sel_data      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) sel_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
`ifdef AXI4STREAM_RR_ARBITER_TID_EN
    skid_in = {TID_W'(0), sel_data};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) skid_in = {TID_W'(i), sel_data};
    end
`else
    skid_in = sel_data;
`endif
  end

  axi4stream_skid_buffer #(
    .WIDTH(PAY_W)
  ) u_skid (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .in_valid (granted_valid),
    .in_ready (skid_in_ready),
    .in_data  (skid_in),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready),
    .out_data (skid_out)
  );

`ifdef AXI4STREAM_RR_ARBITER_TID_EN
  assign {m_axis_tid, m_axis_tdata} = skid_out;
`else
  assign m_axis_tdata = skid_out;
`endif

endmodule
